// File: rtl/psk_pkg.sv
// Shared definitions for the PSK phase accumulator chain: controller state
// encoding, modulation mode constants and default datapath widths.
package psk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_RDY = 3'd1,
      ST_PULSE    = 3'd2,
      ST_GAP      = 3'd3,
      ST_DONE     = 3'd4
   } psk_state_t;

   localparam logic MODE_BPSK = 1'b0;
   localparam logic MODE_QPSK = 1'b1;

   localparam int DEF_PHASE_W  = 32;
   localparam int DEF_ADDR_W   = 12;
   localparam int DEF_CNT_W    = 20;
   localparam int DEF_CODE_MAX = 64;
   localparam int DEF_NIMP_W   = 5;

endpackage

// File: rtl/psk_chip_seq.sv
// Chip sequencer: counts CLK cycles within a chip, steps the chip index and
// turns the current chip symbol into a ROM address offset (phase rotation).
module psk_chip_seq
   import psk_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int CODE_MAX = DEF_CODE_MAX
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  run,
   input  logic [CNT_W-1:0]      chip_len,
   input  logic [6:0]            code_len,
   input  logic [2*CODE_MAX-1:0] code,
   input  logic                  mode_qpsk,
   output logic [ADDR_W-1:0]     offset
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [6:0]            idx_q, idx_d;
   logic [2*CODE_MAX-1:0] code_shift;
   logic [1:0]            sym;

   // chip cycle counter and chip index; index wraps at the code length
   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (clear) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (run) begin
         if (cnt_q == chip_len - CNT_ONE) begin
            cnt_d = '0;
            idx_d = (idx_q == code_len - 7'd1) ? 7'd0 : idx_q + 7'd1;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   // counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   // symbol select and offset mux: BPSK uses only the low bit (0 / 180 deg),
   // QPSK uses both bits as quarter-turn steps
   always_comb begin
      code_shift = code >> {idx_q, 1'b0};
      sym        = code_shift[1:0];
      if (mode_qpsk == MODE_QPSK) begin
         offset = {sym, {(ADDR_W-2){1'b0}}};
      end else begin
         offset = {sym[0], {(ADDR_W-1){1'b0}}};
      end
   end

endmodule

// File: rtl/psk_code_phase_accum.sv
// DDS phase accumulator with per-chip BPSK/QPSK phase rotation and a pulse
// train controller; drives the sine ROM address and output register strobes.
module psk_code_phase_accum
   import psk_pkg::*;
#(
   parameter int PHASE_W  = DEF_PHASE_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int CODE_MAX = DEF_CODE_MAX,
   parameter int NIMP_W   = DEF_NIMP_W
)(
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [PHASE_W-1:0]    FCW,
   input  logic [CNT_W-1:0]      T_IMPULSE,
   input  logic [CNT_W-1:0]      T_PERIOD,
   input  logic [NIMP_W-1:0]     NUM_OF_IMP,
   input  logic [CNT_W-1:0]      CHIP_LEN,
   input  logic [6:0]            CODE_LEN,
   input  logic [2*CODE_MAX-1:0] CODE,
   input  logic                  MODE_QPSK,
   input  logic                  SIGN_START_GEN,
   input  logic                  ABORT,
   input  logic                  OUT_REG_READY,
   output logic [ADDR_W-1:0]     ROM_ADDRESS,
   output logic                  SIGN_START_CALC,
   output logic                  SIGN_STOP_CALC,
   output logic                  BUSY,
   output logic                  CFG_ERR
);

   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [NIMP_W-1:0] NIMP_ONE = {{(NIMP_W-1){1'b0}}, 1'b1};

   psk_state_t state_q, state_d;
   logic       new_pulse;

   logic                  start_prev_q, start_prev_d;
   logic [PHASE_W-1:0]    phase_q, phase_d;
   logic [CNT_W-1:0]      t_q, t_d;
   logic [NIMP_W-1:0]     imp_q, imp_d;
   logic [ADDR_W-1:0]     rom_addr_q, rom_addr_d;
   logic                  stop_q, stop_d;
   logic                  cfg_err_q, cfg_err_d;

   // configuration captured at an accepted start
   logic [PHASE_W-1:0]    fcw_q, fcw_d;
   logic [CNT_W-1:0]      t_imp_q, t_imp_d;
   logic [CNT_W-1:0]      t_per_q, t_per_d;
   logic [NIMP_W-1:0]     num_q, num_d;
   logic [CNT_W-1:0]      chip_len_q, chip_len_d;
   logic [6:0]            code_len_q, code_len_d;
   logic [2*CODE_MAX-1:0] code_q, code_d;
   logic                  mode_q, mode_d;

   logic                  start_rise;
   logic                  cfg_bad;
   logic                  accept;
   logic [CNT_W-1:0]      gap_len;
   logic                  pulse_last;
   logic                  gap_last;
   logic [NIMP_W-1:0]     imp_inc;
   logic [ADDR_W-1:0]     chip_off;

   // shared decode of start request, config check and timer end conditions
   always_comb begin
      start_rise = SIGN_START_GEN & ~start_prev_q;
      cfg_bad    = (T_IMPULSE == '0) || (CHIP_LEN == '0) || (CODE_LEN == 7'd0) ||
                   (int'(CODE_LEN) > CODE_MAX);
      accept     = (state_q == ST_IDLE) && start_rise && !cfg_bad;
      gap_len    = (t_per_q > t_imp_q) ? (t_per_q - t_imp_q) : '0;
      pulse_last = (state_q == ST_PULSE) && (t_q == t_imp_q - CNT_ONE);
      gap_last   = (state_q == ST_GAP) && (t_q == gap_len - CNT_ONE);
      imp_inc    = imp_q + NIMP_ONE;
   end

   // state register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic; a ready output register lets the next pulse start
   // straight from the end of the previous pulse/gap, keeping start-to-start
   // spacing equal to the period
   always_comb begin
      state_d   = state_q;
      new_pulse = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_WAIT_RDY;
         end
         ST_WAIT_RDY: begin
            if (OUT_REG_READY) begin
               state_d   = ST_PULSE;
               new_pulse = 1'b1;
            end
         end
         ST_PULSE: begin
            if (pulse_last) begin
               if (gap_len != '0) begin
                  state_d = ST_GAP;
               end else if ((num_q != '0) && (imp_inc == num_q)) begin
                  state_d = ST_DONE;
               end else if (OUT_REG_READY) begin
                  state_d   = ST_PULSE;
                  new_pulse = 1'b1;
               end else begin
                  state_d = ST_WAIT_RDY;
               end
            end
         end
         ST_GAP: begin
            if (gap_last) begin
               if ((num_q != '0) && (imp_q == num_q)) begin
                  state_d = ST_DONE;
               end else if (OUT_REG_READY) begin
                  state_d   = ST_PULSE;
                  new_pulse = 1'b1;
               end else begin
                  state_d = ST_WAIT_RDY;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (ABORT && (state_q != ST_IDLE)) begin
         state_d   = ST_IDLE;
         new_pulse = 1'b0;
      end
   end

   // state-decoded outputs
   always_comb begin
      SIGN_START_CALC = (state_q == ST_PULSE) && (t_q == '0);
      BUSY            = (state_q != ST_IDLE);
   end

   psk_chip_seq #(
      .CNT_W    (CNT_W),
      .ADDR_W   (ADDR_W),
      .CODE_MAX (CODE_MAX)
   ) u_chip_seq (
      .clk       (CLK),
      .rst       (RESET),
      .clear     (new_pulse),
      .run       (state_q == ST_PULSE),
      .chip_len  (chip_len_q),
      .code_len  (code_len_q),
      .code      (code_q),
      .mode_qpsk (mode_q),
      .offset    (chip_off)
   );

   // datapath next values: config capture, timers, phase and ROM address
   always_comb begin
      start_prev_d = SIGN_START_GEN;
      fcw_d        = fcw_q;
      t_imp_d      = t_imp_q;
      t_per_d      = t_per_q;
      num_d        = num_q;
      chip_len_d   = chip_len_q;
      code_len_d   = code_len_q;
      code_d       = code_q;
      mode_d       = mode_q;
      imp_d        = imp_q;
      if (accept) begin
         fcw_d      = FCW;
         t_imp_d    = T_IMPULSE;
         t_per_d    = T_PERIOD;
         num_d      = NUM_OF_IMP;
         chip_len_d = CHIP_LEN;
         code_len_d = CODE_LEN;
         code_d     = CODE;
         mode_d     = MODE_QPSK;
         imp_d      = '0;
      end else if (pulse_last) begin
         imp_d = imp_inc;
      end
      cfg_err_d = (state_q == ST_IDLE) && start_rise && cfg_bad;

      if (new_pulse || (state_d != state_q)) begin
         t_d = '0;
      end else if ((state_q == ST_PULSE) || (state_q == ST_GAP)) begin
         t_d = t_q + CNT_ONE;
      end else begin
         t_d = '0;
      end

      if (new_pulse) begin
         phase_d = '0;
      end else if ((state_q == ST_PULSE) || (state_q == ST_GAP)) begin
         phase_d = phase_q + fcw_q;
      end else begin
         phase_d = phase_q;
      end

      if ((state_q == ST_PULSE) && !ABORT) begin
         rom_addr_d = phase_q[PHASE_W-1 -: ADDR_W] + chip_off;
      end else begin
         rom_addr_d = '0;
      end
      stop_d = (state_q == ST_PULSE) && (pulse_last || ABORT);
   end

   // datapath registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         start_prev_q <= 1'b0;
         phase_q      <= '0;
         t_q          <= '0;
         imp_q        <= '0;
         rom_addr_q   <= '0;
         stop_q       <= 1'b0;
         cfg_err_q    <= 1'b0;
         fcw_q        <= '0;
         t_imp_q      <= '0;
         t_per_q      <= '0;
         num_q        <= '0;
         chip_len_q   <= '0;
         code_len_q   <= '0;
         code_q       <= '0;
         mode_q       <= MODE_BPSK;
      end else begin
         start_prev_q <= start_prev_d;
         phase_q      <= phase_d;
         t_q          <= t_d;
         imp_q        <= imp_d;
         rom_addr_q   <= rom_addr_d;
         stop_q       <= stop_d;
         cfg_err_q    <= cfg_err_d;
         fcw_q        <= fcw_d;
         t_imp_q      <= t_imp_d;
         t_per_q      <= t_per_d;
         num_q        <= num_d;
         chip_len_q   <= chip_len_d;
         code_len_q   <= code_len_d;
         code_q       <= code_d;
         mode_q       <= mode_d;
      end
   end

   assign ROM_ADDRESS    = rom_addr_q;
   assign SIGN_STOP_CALC = stop_q;
   assign CFG_ERR        = cfg_err_q;

endmodule

// File: tb/tb_psk_code_phase_accum.sv
// Scoreboard bench for psk_code_phase_accum: stimulus pushes expected
// strobe/address events (cycle relative to the start request), a negedge
// monitor pops and compares them as the DUT produces them.
module tb_psk_code_phase_accum;

   localparam int K_ADDR  = 0;
   localparam int K_STOP  = 1;
   localparam int K_START = 2;
   localparam int K_CFG   = 3;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic [31:0]   FCW = '0;
   logic [19:0]   T_IMPULSE = '0;
   logic [19:0]   T_PERIOD = '0;
   logic [4:0]    NUM_OF_IMP = '0;
   logic [19:0]   CHIP_LEN = '0;
   logic [6:0]    CODE_LEN = '0;
   logic [127:0]  CODE = '0;
   logic          MODE_QPSK = 1'b0;
   logic          SIGN_START_GEN = 1'b0;
   logic          ABORT = 1'b0;
   logic          OUT_REG_READY = 1'b1;
   logic [11:0]   ROM_ADDRESS;
   logic          SIGN_START_CALC;
   logic          SIGN_STOP_CALC;
   logic          BUSY;
   logic          CFG_ERR;

   psk_code_phase_accum dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .FCW             (FCW),
      .T_IMPULSE       (T_IMPULSE),
      .T_PERIOD        (T_PERIOD),
      .NUM_OF_IMP      (NUM_OF_IMP),
      .CHIP_LEN        (CHIP_LEN),
      .CODE_LEN        (CODE_LEN),
      .CODE            (CODE),
      .MODE_QPSK       (MODE_QPSK),
      .SIGN_START_GEN  (SIGN_START_GEN),
      .ABORT           (ABORT),
      .OUT_REG_READY   (OUT_REG_READY),
      .ROM_ADDRESS     (ROM_ADDRESS),
      .SIGN_START_CALC (SIGN_START_CALC),
      .SIGN_STOP_CALC  (SIGN_STOP_CALC),
      .BUSY            (BUSY),
      .CFG_ERR         (CFG_ERR)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int rel;
      int val;
   } exp_t;

   exp_t q[$];
   int   t0 = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   bit   win = 1'b0;

   // burst configuration used by both the driver and the address model
   logic [31:0]  fcw_v;
   logic [127:0] code_v;
   bit           qpsk_v;
   int           timp_v, tper_v, num_v, chlen_v, clen_v;

   function automatic string kname(input int k);
      case (k)
         K_ADDR:  return "addr";
         K_STOP:  return "stop";
         K_START: return "start";
         default: return "cfg_err";
      endcase
   endfunction

   // reference address for pulse cycle k
   function automatic int exp_addr(input int k);
      logic [31:0]  ph;
      logic [127:0] sh;
      logic [1:0]   sym;
      int           idx, off;
      ph  = fcw_v * 32'(k);
      idx = (k / chlen_v) % clen_v;
      sh  = code_v >> (2 * idx);
      sym = sh[1:0];
      if (qpsk_v) off = int'(sym) * 1024;
      else        off = sym[0] ? 2048 : 0;
      return (int'(ph[31:20]) + off) % 4096;
   endfunction

   task automatic push(input int kind, input int rel, input int val);
      exp_t e;
      e.kind = kind;
      e.rel  = rel;
      e.val  = val;
      q.push_back(e);
   endtask

   // expected events of one pulse starting at rel s; ka>=0 = abort in pulse cycle ka
   task automatic push_pulse(input int s, input int ka);
      int n;
      push(K_START, s, 0);
      n = (ka < 0) ? timp_v : ka;
      for (int k = 0; k < n; k++) push(K_ADDR, s + 1 + k, exp_addr(k));
      if (ka >= 0) begin
         push(K_ADDR, s + 1 + ka, 0);
         push(K_STOP, s + 1 + ka, 0);
      end else begin
         push(K_STOP, s + timp_v, 0);
      end
   endtask

   task automatic sb_pop(input int kind, input int val);
      exp_t e;
      int   rel;
      rel = cyc - t0;
      n_tests++;
      if (q.size() == 0) begin
         n_fail++;
         $display("FAIL sb_unexpected_%s rel=%0d got=%0d required=nothing", kname(kind), rel, val);
      end else begin
         e = q.pop_front();
         if (e.kind != kind || e.rel != rel || e.val != val) begin
            n_fail++;
            $display("FAIL sb_%s got kind=%s rel=%0d val=%0d required kind=%s rel=%0d val=%0d",
                     kname(e.kind), kname(kind), rel, val, kname(e.kind), e.rel, e.val);
         end else begin
            $display("[TB] %s rel=%0d val=%0d ok", kname(kind), rel, val);
         end
      end
   endtask

   // monitor: address window runs from the cycle after START_CALC to STOP_CALC
   always @(negedge CLK) begin
      if (RESET || !mon_en) begin
         win = 1'b0;
      end else begin
         if (win) sb_pop(K_ADDR, int'(ROM_ADDRESS));
         if (SIGN_STOP_CALC) begin
            sb_pop(K_STOP, 0);
            win = 1'b0;
         end
         if (SIGN_START_CALC) begin
            sb_pop(K_START, 0);
            win = 1'b1;
         end
         if (CFG_ERR) sb_pop(K_CFG, 0);
      end
   end

   task automatic chk(input string nm, input int got, input int req);
      n_tests++;
      if (got != req) begin
         n_fail++;
         $display("FAIL %s got=%0d required=%0d", nm, got, req);
      end else begin
         $display("[TB] %s = %0d ok", nm, got);
      end
   endtask

   task automatic wait_rel(input int n);
      while ((cyc - t0) < n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wait_idle(input string nm, input int req);
      int r;
      r = -1;
      for (int i = 0; i < 100; i++) begin
         if (!BUSY) begin
            r = cyc - t0;
            break;
         end
         @(posedge CLK);
         #1;
      end
      chk(nm, r, req);
   endtask

   task automatic set_cfg(input logic [31:0] f, input int ti, input int tp, input int nm,
                          input int chl, input int cl, input logic [127:0] cd, input bit qp);
      fcw_v = f; timp_v = ti; tper_v = tp; num_v = nm;
      chlen_v = chl; clen_v = cl; code_v = cd; qpsk_v = qp;
   endtask

   // drive config, raise start for one cycle; t0 = cycle of the request
   task automatic start_burst();
      FCW        = fcw_v;
      T_IMPULSE  = 20'(timp_v);
      T_PERIOD   = 20'(tper_v);
      NUM_OF_IMP = 5'(num_v);
      CHIP_LEN   = 20'(chlen_v);
      CODE_LEN   = 7'(clen_v);
      CODE       = code_v;
      MODE_QPSK  = qpsk_v;
      SIGN_START_GEN = 1'b1;
      t0 = cyc;
      @(posedge CLK);
      #1;
      SIGN_START_GEN = 1'b0;
   endtask

   task automatic settle(input string nm, input int n);
      wait_rel(n);
      chk(nm, q.size(), 0);
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_rom_address", int'(ROM_ADDRESS), 0);
      chk("reset_busy", int'(BUSY), 0);
      chk("reset_strobes", int'({SIGN_START_CALC, SIGN_STOP_CALC, CFG_ERR}), 0);
      RESET = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(posedge CLK);
      #1;

      // 1: BPSK, code 0, two pulses with gap
      set_cfg(32'h4000_0000, 8, 12, 2, 8, 1, 128'h0, 1'b0);
      start_burst();
      push_pulse(2, -1);
      push_pulse(14, -1);
      wait_rel(2);
      wait_idle("t1_busy_fall", 27);
      settle("t1_queue_empty", 30);

      // 2: two chips of 4 cycles, chip 1 rotated by 180 degrees
      set_cfg(32'h4000_0000, 8, 12, 2, 4, 2, 128'h4, 1'b0);
      start_burst();
      push_pulse(2, -1);
      push_pulse(14, -1);
      wait_rel(2);
      wait_idle("t2_busy_fall", 27);
      settle("t2_queue_empty", 30);

      // 3a: QPSK chip 11, FCW 0 -> constant 3072
      set_cfg(32'h0, 8, 8, 1, 8, 1, 128'h3, 1'b1);
      start_burst();
      push_pulse(2, -1);
      wait_rel(2);
      wait_idle("t3a_busy_fall", 11);
      settle("t3a_queue_empty", 14);

      // 3b: QPSK with address wrap, back-to-back pulses, code index wrap
      set_cfg(32'h4000_0000, 6, 6, 2, 2, 2, 128'h7, 1'b1);
      start_burst();
      push_pulse(2, -1);
      push_pulse(8, -1);
      wait_rel(2);
      wait_idle("t3b_busy_fall", 15);
      settle("t3b_queue_empty", 18);

      // 4: READY low for 5 cycles at the decision point delays pulse 2 by 5
      set_cfg(32'h4000_0000, 8, 12, 2, 8, 1, 128'h0, 1'b0);
      start_burst();
      push_pulse(2, -1);
      push_pulse(19, -1);
      wait_rel(13);
      OUT_REG_READY = 1'b0;
      wait_rel(18);
      OUT_REG_READY = 1'b1;
      wait_idle("t4_busy_fall", 32);
      settle("t4_queue_empty", 35);

      // 5a: ABORT in pulse cycle 3
      set_cfg(32'h4000_0000, 8, 12, 2, 8, 1, 128'h0, 1'b0);
      start_burst();
      push_pulse(2, 3);
      wait_rel(5);
      ABORT = 1'b1;
      wait_rel(6);
      ABORT = 1'b0;
      wait_idle("t5a_busy_fall", 6);
      settle("t5a_queue_empty", 20);

      // 5b: asynchronous reset mid-pulse clears outputs at once
      mon_en = 1'b0;
      start_burst();
      wait_rel(6);
      #2;
      RESET = 1'b1;
      #1;
      chk("t5b_rom_address", int'(ROM_ADDRESS), 0);
      chk("t5b_busy", int'(BUSY), 0);
      chk("t5b_strobes", int'({SIGN_START_CALC, SIGN_STOP_CALC, CFG_ERR}), 0);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      mon_en = 1'b1;

      // 6a: rejected configurations
      for (int c = 0; c < 4; c++) begin
         case (c)
            0: set_cfg(32'h4000_0000, 0, 12, 2, 8, 1, 128'h0, 1'b0);
            1: set_cfg(32'h4000_0000, 8, 12, 2, 0, 1, 128'h0, 1'b0);
            2: set_cfg(32'h4000_0000, 8, 12, 2, 8, 0, 128'h0, 1'b0);
            default: set_cfg(32'h4000_0000, 8, 12, 2, 8, 65, 128'h0, 1'b0);
         endcase
         start_burst();
         push(K_CFG, 1, 0);
         wait_rel(3);
         chk($sformatf("t6a_busy_cfg%0d", c), int'(BUSY), 0);
         settle($sformatf("t6a_queue_empty_cfg%0d", c), 5);
      end

      // 6b: NUM_OF_IMP=0 keeps running; ABORT on a pulse's last cycle wins
      set_cfg(32'h8000_0000, 2, 3, 0, 1, 1, 128'h0, 1'b0);
      start_burst();
      for (int p = 0; p < 5; p++) push_pulse(2 + 3 * p, -1);
      push_pulse(17, 1);
      wait_rel(18);
      ABORT = 1'b1;
      wait_rel(19);
      ABORT = 1'b0;
      wait_idle("t6b_busy_fall", 19);
      settle("t6b_queue_empty", 24);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
